regfile_write_scheduler: RTL and testbench

- Controls the pipeline's single register-file write port and its read-after-write safety.
- Two writeback requesters compete for the one write port through round-robin arbitration:
  - requester A: ALU result path;
  - requester B: memory load path.
- A per-register pending-write scoreboard is set when a destination-writing instruction issues and cleared when its result is written.
- Decode is stalled whenever a source or destination register has a write outstanding.

---
 rtl/regfile_write_scheduler_if.sv | 43 ++++
 rtl/regfile_write_scheduler.sv | 104 ++++++++++
 tb/tb_regfile_write_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_scheduler_if.sv
// Issue, writeback-request and write-port signals of the
// register-file write scheduler.
interface regfile_write_scheduler_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
);
  logic                iss_valid;
  logic                iss_wr;
  logic [ADDR_W-1:0]   iss_dst;
  logic [ADDR_W-1:0]   iss_src1;
  logic [ADDR_W-1:0]   iss_src2;
  logic                iss_stall;
  logic                a_valid;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_data;
  logic                a_ready;
  logic                b_valid;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_data;
  logic                b_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] busy_vec;
  logic                err;

  modport master (
    output iss_valid, iss_wr, iss_dst, iss_src1, iss_src2,
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  iss_stall, a_ready, b_ready,
    input  wr_en, wr_addr, wr_data, busy_vec, err
  );

  modport slave (
    input  iss_valid, iss_wr, iss_dst, iss_src1, iss_src2,
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output iss_stall, a_ready, b_ready,
    output wr_en, wr_addr, wr_data, busy_vec, err
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter for the single register-file write port
// plus the pending-write scoreboard that drives the decode stall.
module regfile_write_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  regfile_write_scheduler_if.slave bus
);

  typedef enum logic {PTR_A, PTR_B} ptr_e;

  ptr_e                ptr_q, ptr_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                err_q, err_d;

  logic                gnt_a, gnt_b, gnt;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_data;
  logic                stall, issue;

  // busy_q[0] is never set, so r0 cannot stall
  assign stall = bus.iss_valid &
                 (busy_q[bus.iss_src1] |
                  busy_q[bus.iss_src2] |
                  (bus.iss_wr & busy_q[bus.iss_dst]));

  assign issue = bus.iss_valid & ~stall & bus.iss_wr &
                 (bus.iss_dst != '0);

  always_comb begin
    gnt_a = bus.a_valid & (~bus.b_valid | (ptr_q == PTR_A));
    gnt_b = bus.b_valid & (~bus.a_valid | (ptr_q == PTR_B));
    gnt   = gnt_a | gnt_b;
    g_addr = '0;
    g_data = '0;
    unique case (1'b1)
      gnt_a: begin
        g_addr = bus.a_addr;
        g_data = bus.a_data;
      end
      gnt_b: begin
        g_addr = bus.b_addr;
        g_data = bus.b_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    if (gnt) begin
      ptr_d     = gnt_a ? PTR_B : PTR_A;
      wr_addr_d = g_addr;
      wr_data_d = g_data;
      if (g_addr != '0) begin
        wr_en_d        = 1'b1;
        busy_d[g_addr] = 1'b0;
        if (!busy_q[g_addr]) err_d = 1'b1;
      end
    end
    // set after clear: a same-edge set wins
    if (issue) busy_d[bus.iss_dst] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= PTR_A;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.iss_stall = stall;
  assign bus.a_ready   = gnt_a;
  assign bus.b_ready   = gnt_b;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy_vec  = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed-vector bench for regfile_write_scheduler.
// Inputs change 1ns after a rising edge; outputs are sampled before the next.
module tb_regfile_write_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler_if #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32)
  ) bus ();

  regfile_write_scheduler #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_wr    = 1'b0;
    bus.iss_dst   = '0;
    bus.iss_src1  = '0;
    bus.iss_src2  = '0;
    bus.a_valid   = 1'b0;
    bus.a_addr    = '0;
    bus.a_data    = '0;
    bus.b_valid   = 1'b0;
    bus.b_addr    = '0;
    bus.b_data    = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.iss_valid = 1'b1;
    bus.iss_wr    = 1'b1;
    bus.iss_dst   = 5'd9;
    tick();
    bus.iss_dst   = 5'd10;
    tick();
    bus.iss_valid = 1'b0;
    bus.iss_wr    = 1'b0;
    bus.a_valid   = 1'b1;
    bus.a_addr    = 5'd9;
    bus.a_data    = 32'h0000_1234;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_ready got %b exp 1", bus.a_ready);
    end
    tick();
    bus.a_valid = 1'b0;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.busy_vec !== 32'h0000_0400) begin
      errors++;
      $display("FAIL rst_pre_state wr_en %b busy %h exp 1 00000400",
               bus.wr_en, bus.busy_vec);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_en got %b exp 0", bus.wr_en);
    end
    checks++;
    if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_wr_bus got %h/%h exp 0/0",
               bus.wr_addr, bus.wr_data);
    end
    checks++;
    if (bus.busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL rst_busy got %h exp 0", bus.busy_vec);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %b exp 0", bus.err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    bus.iss_valid = 1'b1;
    bus.iss_wr    = 1'b1;
    bus.iss_dst   = 5'd5;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_issue_stall got %b exp 0", bus.iss_stall);
    end
    tick();
    bus.iss_wr   = 1'b0;
    bus.iss_dst  = 5'd0;
    bus.iss_src1 = 5'd5;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b1 || bus.busy_vec !== 32'h0000_0020) begin
      errors++;
      $display("FAIL raw_stall stall %b busy %h exp 1 00000020",
               bus.iss_stall, bus.busy_vec);
    end
    bus.iss_src1 = 5'd0;
    bus.iss_dst  = 5'd5;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_dst_nowr got %b exp 0", bus.iss_stall);
    end
    bus.iss_wr = 1'b1;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall got %b exp 1", bus.iss_stall);
    end
    bus.iss_wr   = 1'b0;
    bus.iss_dst  = 5'd0;
    bus.iss_src2 = 5'd5;
    bus.a_valid  = 1'b1;
    bus.a_addr   = 5'd5;
    bus.a_data   = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.iss_stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_grant ready %b stall %b exp 1 1",
               bus.a_ready, bus.iss_stall);
    end
    tick();
    bus.a_valid = 1'b0;
    #1;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 ||
        bus.wr_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL raw_write got %b %h %h exp 1 05 deadbeef",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    checks++;
    if (bus.busy_vec !== 32'd0 || bus.iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_release busy %h stall %b exp 0 0",
               bus.busy_vec, bus.iss_stall);
    end
    idle();
    tick();
    checks++;
    if (bus.wr_en !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL raw_after wr_en %b err %b exp 0 0",
               bus.wr_en, bus.err);
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    bus.iss_valid = 1'b1;
    bus.iss_wr    = 1'b1;
    bus.iss_dst   = 5'd3;
    tick();
    bus.iss_dst   = 5'd4;
    tick();
    idle();
    checks++;
    if (bus.busy_vec !== 32'h0000_0018) begin
      errors++;
      $display("FAIL cont_busy got %h exp 00000018", bus.busy_vec);
    end
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd3;
    bus.a_data  = 32'h3333_3333;
    bus.b_valid = 1'b1;
    bus.b_addr  = 5'd4;
    bus.b_data  = 32'h4444_4444;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++;
      $display("FAIL cont_first a %b b %b exp 1 0",
               bus.a_ready, bus.b_ready);
    end
    tick();
    bus.a_valid = 1'b0;
    #1;
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL cont_second a %b b %b exp 0 1",
               bus.a_ready, bus.b_ready);
    end
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 ||
        bus.wr_data !== 32'h3333_3333 ||
        bus.busy_vec !== 32'h0000_0010) begin
      errors++;
      $display("FAIL cont_wr3 got %b %h %h %h exp 1 03 33333333 00000010",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy_vec);
    end
    tick();
    bus.b_valid = 1'b0;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd4 ||
        bus.wr_data !== 32'h4444_4444 || bus.busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL cont_wr4 got %b %h %h %h exp 1 04 44444444 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy_vec);
    end
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd0;
    bus.b_valid = 1'b1;
    bus.b_addr  = 5'd0;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++;
      $display("FAIL cont_ptr_back a %b b %b exp 1 0",
               bus.a_ready, bus.b_ready);
    end
    idle();
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL cont_err got %b exp 0", bus.err);
    end
  endtask

  task automatic test_fairness();
    logic exp_a, exp_b;
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      exp_a = (i % 2) == 0;
      exp_b = (i % 2) == 1;
      if (i < 8) begin
        bus.a_valid = (i % 2) == 0;
        bus.b_valid = (i == 0) || ((i % 2) == 1);
      end else begin
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
      end
      bus.a_addr = 5'd0;
      bus.b_addr = 5'd0;
      #1;
      checks++;
      if (bus.a_ready !== exp_a || bus.b_ready !== exp_b) begin
        errors++;
        $display("FAIL fair_%0d a %b b %b exp %b %b",
                 i, bus.a_ready, bus.b_ready, exp_a, exp_b);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reg0();
    bus.iss_valid = 1'b1;
    bus.iss_wr    = 1'b1;
    bus.iss_dst   = 5'd0;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL r0_issue_stall got %b exp 0", bus.iss_stall);
    end
    tick();
    bus.iss_wr = 1'b0;
    #1;
    checks++;
    if (bus.busy_vec !== 32'd0 || bus.iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL r0_busy busy %h stall %b exp 0 0",
               bus.busy_vec, bus.iss_stall);
    end
    bus.iss_valid = 1'b0;
    bus.b_valid   = 1'b1;
    bus.b_addr    = 5'd0;
    bus.b_data    = 32'h0000_0077;
    #1;
    checks++;
    if (bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_ready got %b exp 1", bus.b_ready);
    end
    tick();
    bus.b_valid = 1'b0;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.busy_vec !== 32'd0 ||
        bus.err !== 1'b0) begin
      errors++;
      $display("FAIL r0_write wr_en %b busy %h err %b exp 0 0 0",
               bus.wr_en, bus.busy_vec, bus.err);
    end
    tick();
  endtask

  task automatic test_orphan();
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd7;
    bus.a_data  = 32'h0000_CAFE;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL orph_ready got %b exp 1", bus.a_ready);
    end
    tick();
    bus.a_valid = 1'b0;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 ||
        bus.wr_data !== 32'h0000_CAFE || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL orph_write got %b %h %h err %b exp 1 07 0000cafe 1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.err);
    end
    tick();
    tick();
    checks++;
    if (bus.err !== 1'b1 || bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL orph_sticky err %b wr_en %b exp 1 0",
               bus.err, bus.wr_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL orph_reset err got %b exp 0", bus.err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    #3;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.busy_vec !== 32'd0 ||
        bus.err !== 1'b0) begin
      errors++;
      $display("FAIL init_reset wr_en %b busy %h err %b exp 0 0 0",
               bus.wr_en, bus.busy_vec, bus.err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_reset();
    test_raw();
    test_contention();
    test_fairness();
    test_reg0();
    test_orphan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
